dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit on the CPU side of the data-memory port; it is the initiator that drives the word-addressed dmem request interface (addr, write_data, mem_read, mem_write, stall, read_data, done).
- Accepts one pipeline load/store at a time (byte/half/word, signed/unsigned) and converts byte addresses to word indices.
- Performs read-modify-write for sub-word stores, since memory is word-only.
- Returns load data or a store acknowledgement to the MEM stage.

Parameters:
- RD_LATENCY, 1, cycles from the mem_read sample edge to read_data valid (1..3).
- WORD_IDX_W, 8, word-index bits meaningful to memory; upper mem_addr bits driven 0.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU idle and pipe_stall low.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- req_signed  in  1  sign-extend load result.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal size.
- pipe_stall  in  1  pipeline freeze.
- mem_addr  out  32  word index = req_addr[WORD_IDX_W+1:2], zero-extended.
- mem_wdata  out  32  word to write.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_stall  out  1  equals pipe_stall, combinational.
- mem_rdata  in  32  memory read_data.
- mem_done  in  1  memory done.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, wait counter 0, all registered outputs 0. Reset mid-operation aborts the access; no resp_valid is produced.
- States: IDLE, RD, RD_WAIT, WR, RESP.
- IDLE: req_ready=1 when pipe_stall=0. On accept, latch addr, size, signed, wdata and we.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or size=3: go to RESP with err=1; no memory access.
  - Load or sub-word store: go to RD.
  - Word store: go to WR.
- RD: mem_read=1 for one cycle, then RD_WAIT with counter=RD_LATENCY.
- RD_WAIT: counter decrements each unstalled cycle. Capture mem_rdata when counter reaches 0 and mem_done=1; stay in RD_WAIT while mem_done=0.
  - Load: go to RESP.
  - Sub-word store: merge wdata into the captured word by lane (little-endian: byte lane addr[1:0], half lane addr[1]), then go to WR.
- WR: mem_write=1 and mem_wdata valid for one cycle, then RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
  - resp_rdata holds the extracted lane, zero- or sign-extended to 32 bits.
  - Store acknowledgements carry rdata=0.
- pipe_stall=1: the FSM holds its state and counter, req_ready=0, and mem_read/mem_write/mem_addr/mem_wdata are held stable (memory ignores them while stalled). A RESP state held under stall keeps resp_valid high until the first unstalled cycle.
- Latency from the accept edge, no stall, RD_LATENCY=1:
  - Load: resp_valid in cycle 3.
  - Word store: resp_valid in cycle 2.
  - Sub-word store: resp_valid in cycle 4.
  - Misaligned/illegal: resp_valid in cycle 1.
- Back-to-back: a new request can be accepted in the cycle after RESP. No pipelining of requests.
- mem_read and mem_write are never asserted together.
- Address bits above WORD_IDX_W+1 are ignored, so addresses wrap at memory size.

Decomposition:
- Shared package (cpu_pkg): SIZE_BYTE/HALF/WORD encodings and the lsu_state_t enum.
- One sub-module: lsu_lane_align, combinational.
  - Load extract and extend: word, addr[1:0], size, signed -> 32 bits.
  - Store merge: old word, wdata, addr[1:0], size -> 32 bits.

Test Plan:
- Word store, addr 0x10, data 0xDEADBEEF, then word load at 0x10 -> mem_addr=4 with mem_write=1 one cycle; load resp_rdata=0xDEADBEEF, resp_valid 3 cycles after accept.
- Memory word 4 = 0x80FF7F01; signed byte load at 0x13 -> 0xFFFFFF80; unsigned byte load at 0x13 -> 0x00000080; signed half load at 0x10 -> 0x00007F01.
- Byte store 0xAA to addr 0x11 with word 4 = 0x11223344 -> mem_read, then mem_write with mem_wdata=0x1122AA44; resp_valid 4 cycles after accept.
- Half load at 0x11, then word store at 0x12 -> resp_err=1 in the cycle after accept; mem_read/mem_write never asserted.
- pipe_stall=1 for 3 cycles while in RD -> mem_stall=1, mem_read and mem_addr held; result identical to the unstalled run, delayed by exactly 3 cycles.
- reset low while in RD_WAIT -> outputs 0 immediately; no resp_valid; next request completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared LSU definitions: access-size encodings, FSM states and
// the alignment rule used when a request is accepted.
package cpu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_RD,
        LSU_RD_WAIT,
        LSU_WR,
        LSU_RESP
    } lsu_state_t;

    function automatic logic access_err(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic e;
        unique case (size)
            SIZE_BYTE: e = 1'b0;
            SIZE_HALF: e = off[0];
            SIZE_WORD: e = (off != 2'b00);
            default:   e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: load extract/extend and store merge
// into a full memory word.
module lsu_lane_align
    import cpu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;

    always_comb begin
        sh   = {off_i, 3'b000};
        lane = word_i >> sh;
        unique case (size_i)
            SIZE_BYTE: begin
                load_o = {{24{signed_i & lane[7]}}, lane[7:0]};
                mask   = 32'h0000_00FF << sh;
            end
            SIZE_HALF: begin
                load_o = {{16{signed_i & lane[15]}}, lane[15:0]};
                mask   = 32'h0000_FFFF << sh;
            end
            default: begin
                load_o = word_i;
                mask   = 32'hFFFF_FFFF;
            end
        endcase
        store_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving the word-addressed data memory port;
// sub-word stores are done as read-modify-write.
module dmem_lsu
    import cpu_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int WORD_IDX_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        pipe_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_stall,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done,
    output logic        busy
);

    localparam logic [1:0] LAT = 2'(RD_LATENCY);

    lsu_state_t  state_q;
    logic [1:0]  cnt_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        req_err;
    logic [31:0] load_val;
    logic [31:0] store_val;
    logic        unused_addr;

    assign req_err     = access_err(req_size, req_addr[1:0]);
    assign unused_addr = ^req_addr;

    lsu_lane_align u_align (
        .word_i   (mem_rdata),
        .wdata_i  (wdata_q),
        .off_i    (off_q),
        .size_i   (size_q),
        .signed_i (sgn_q),
        .load_o   (load_val),
        .store_o  (store_val)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LSU_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            size_q       <= '0;
            sgn_q        <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else if (!pipe_stall) begin
            unique case (state_q)
                LSU_IDLE: begin
                    if (req_valid) begin
                        off_q      <= req_addr[1:0];
                        size_q     <= req_size;
                        sgn_q      <= req_signed;
                        we_q       <= req_we;
                        wdata_q    <= req_wdata;
                        mem_addr_q <= 32'(req_addr[WORD_IDX_W+1:2]);
                        if (req_err) begin
                            state_q      <= LSU_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_we && req_size == SIZE_WORD) begin
                            state_q     <= LSU_WR;
                            mem_write_q <= 1'b1;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q    <= LSU_RD;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                LSU_RD: begin
                    mem_read_q <= 1'b0;
                    cnt_q      <= LAT;
                    state_q    <= LSU_RD_WAIT;
                end
                LSU_RD_WAIT: begin
                    // The edge that takes the counter to zero is the capture edge.
                    if (cnt_q > 2'd1) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        cnt_q <= '0;
                        if (mem_done) begin
                            if (we_q) begin
                                state_q     <= LSU_WR;
                                mem_write_q <= 1'b1;
                                mem_wdata_q <= store_val;
                            end else begin
                                state_q      <= LSU_RESP;
                                resp_valid_q <= 1'b1;
                                resp_err_q   <= 1'b0;
                                resp_rdata_q <= load_val;
                            end
                        end
                    end
                end
                LSU_WR: begin
                    mem_write_q  <= 1'b0;
                    state_q      <= LSU_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                LSU_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    state_q      <= LSU_IDLE;
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == LSU_IDLE) && !pipe_stall;
    assign busy       = (state_q != LSU_IDLE);
    assign mem_stall  = pipe_stall;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: word memory model plus a request-level
// reference model and scoreboard.
module tb_dmem_lsu;
    import cpu_pkg::*;

    localparam int LAT = 1;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        pipe_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_stall, mem_done, busy;

    dmem_lsu #(.RD_LATENCY(LAT), .WORD_IDX_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .pipe_stall(pipe_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // memory: read data valid LAT cycles after an unstalled read edge
    bit [31:0] bfm_mem [256];
    bit [31:0] rd_q;
    bit        pend;
    int        rem;
    bit        extra_en;

    always @(posedge clk) begin
        if (!mem_stall && mem_write)
            bfm_mem[mem_addr[7:0]] <= mem_wdata;
        if (!mem_stall && mem_read) begin
            rd_q <= bfm_mem[mem_addr[7:0]];
            pend <= 1'b1;
            rem  <= LAT - 1 + (extra_en ? int'($urandom_range(0, 2)) : 0);
        end else if (pend && rem > 0) begin
            rem <= rem - 1;
        end
    end

    assign mem_done  = pend && (rem == 0);
    assign mem_rdata = mem_done ? rd_q : 32'hBAD0_BAD0;

    // reference model
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t      q[$];
    bit [31:0] ref_mem [256];
    logic [31:0] cur_idx, cur_wexp;
    bit        cur_err, cur_rd, hold_rd;
    int        chk_cnt, pass_cnt, tmo_cnt;

    function automatic logic [31:0] m_load(input logic [31:0] w,
        input logic [1:0] a, input logic [1:0] sz, input bit sg);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = w[16*a[1] +: 16];
        if (sz == SIZE_BYTE)
            return sg ? 32'($signed(b)) : {24'd0, b};
        if (sz == SIZE_HALF)
            return sg ? 32'($signed(h)) : {16'd0, h};
        return w;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w,
        input logic [31:0] d, input logic [1:0] a, input logic [1:0] sz);
        logic [31:0] r;
        r = w;
        if (sz == SIZE_BYTE) r[8*a +: 8] = d[7:0];
        else if (sz == SIZE_HALF) r[16*a[1] +: 16] = d[15:0];
        else r = d;
        return r;
    endfunction

    task automatic chk(input string nm, input bit ok,
        input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   l;
        if (!reset) begin
            chk("reset_out",
                {resp_valid, resp_err, mem_read, mem_write, busy} == 5'd0
                && mem_addr == 0 && mem_wdata == 0 && resp_rdata == 0,
                {27'd0, resp_valid, resp_err, mem_read, mem_write, busy}, 0);
        end else begin
            chk("mem_stall", mem_stall === pipe_stall, {31'd0, mem_stall}, {31'd0, pipe_stall});
            if (mem_read || mem_write) begin
                chk("strobe_excl", !(mem_read && mem_write), {30'd0, mem_read, mem_write}, 0);
                chk("mem_addr", mem_addr === cur_idx, mem_addr, cur_idx);
                chk("no_mem_on_err", !cur_err, {31'd0, cur_err}, 0);
            end
            if (mem_read)
                chk("read_expected", cur_rd, {31'd0, cur_rd}, 1);
            if (mem_write && !pipe_stall)
                chk("mem_wdata", mem_wdata === cur_wexp, mem_wdata, cur_wexp);
            if (hold_rd)
                chk("stall_hold_rd", mem_read === 1'b1 && mem_addr === cur_idx,
                    {mem_read, mem_addr[30:0]}, {1'b1, cur_idx[30:0]});
            if (resp_valid && !pipe_stall) begin
                if (q.size() == 0) begin
                    chk("spurious_resp", 1'b0, {31'd0, resp_valid}, 0);
                end else begin
                    e = q.pop_front();
                    chk("resp_rdata", resp_rdata === e.rdata, resp_rdata, e.rdata);
                    chk("resp_err", resp_err === e.err, {31'd0, resp_err}, {31'd0, e.err});
                    if (e.chk_lat) begin
                        l = cyc - e.acc + 1;
                        chk("latency", l == e.lat, l, e.lat);
                    end
                end
            end
        end
    end

    task automatic issue(input bit we, input logic [1:0] sz, input bit sg,
        input logic [31:0] a, input logic [31:0] wd, input bit lit,
        input logic [31:0] lr, input logic [31:0] lw, input int stall_n,
        input bit rnd);
        bit   ok;
        exp_t e;
        logic [7:0] idx;
        logic [31:0] w;
        req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
            @(posedge clk); #1;
            if (rnd) pipe_stall = ($urandom_range(0, 3) == 0);
        end
        if (!ok) begin
            $display("FAIL accept_timeout: got busy want ready");
            tmo_cnt++;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        idx = a[9:2];
        w = ref_mem[idx];
        e.acc = cyc;
        e.chk_lat = !rnd;
        cur_idx = {24'd0, idx};
        cur_err = (sz == 2'd3) || (sz == SIZE_HALF && a[0])
                  || (sz == SIZE_WORD && a[1:0] != 2'b00);
        cur_rd = !cur_err && !(we && sz == SIZE_WORD);
        e.err = cur_err;
        e.rdata = 0;
        cur_wexp = 0;
        if (cur_err) begin
            e.lat = 1;
        end else if (!we) begin
            e.rdata = lit ? lr : m_load(w, a[1:0], sz, sg);
            e.lat = 2 + LAT;
        end else begin
            cur_wexp = lit ? lw : m_merge(w, wd, a[1:0], sz);
            ref_mem[idx] = m_merge(w, wd, a[1:0], sz);
            e.lat = (sz == SIZE_WORD) ? 2 : 3 + LAT;
        end
        e.lat += stall_n;
        q.push_back(e);
        if (stall_n > 0) begin
            pipe_stall = 1'b1;
            hold_rd = 1'b1;
            repeat (stall_n) @(posedge clk);
            #1;
            pipe_stall = 1'b0;
            hold_rd = 1'b0;
        end else if (rnd) begin
            pipe_stall = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic wait_idle(input bit rnd);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (rnd) pipe_stall = ($urandom_range(0, 3) == 0);
            if (!busy && !pipe_stall) return;
        end
        $display("FAIL idle_timeout: got busy want idle");
        tmo_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'd0; req_signed = 1'b0; req_addr = 0;
        req_wdata = 0; pipe_stall = 1'b0; hold_rd = 1'b0;
        cur_idx = 0; cur_wexp = 0; cur_err = 0; cur_rd = 0;
        extra_en = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // word store then back-to-back word load
        issue(1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0, 0);
        issue(0, SIZE_WORD, 0, 32'h10, 0, 1, 32'hDEADBEEF, 0, 0, 0);
        wait_idle(0);

        // byte/half extraction from 0x80FF7F01
        issue(1, SIZE_WORD, 0, 32'h10, 32'h80FF7F01, 1, 0, 32'h80FF7F01, 0, 0);
        issue(0, SIZE_BYTE, 1, 32'h13, 0, 1, 32'hFFFFFF80, 0, 0, 0);
        issue(0, SIZE_BYTE, 0, 32'h13, 0, 1, 32'h00000080, 0, 0, 0);
        issue(0, SIZE_HALF, 1, 32'h10, 0, 1, 32'h00007F01, 0, 0, 0);
        issue(0, SIZE_HALF, 1, 32'h12, 0, 1, 32'hFFFF80FF, 0, 0, 0);

        // read-modify-write byte store
        issue(1, SIZE_WORD, 0, 32'h10, 32'h11223344, 1, 0, 32'h11223344, 0, 0);
        issue(1, SIZE_BYTE, 0, 32'h11, 32'h000000AA, 1, 0, 32'h1122AA44, 0, 0);
        issue(0, SIZE_WORD, 0, 32'h10, 0, 1, 32'h1122AA44, 0, 0, 0);

        // misaligned and illegal size
        issue(0, SIZE_HALF, 0, 32'h11, 0, 1, 0, 0, 0, 0);
        issue(1, SIZE_WORD, 0, 32'h12, 32'h5, 1, 0, 0, 0, 0);
        issue(0, 2'd3, 0, 32'h10, 0, 1, 0, 0, 0, 0);
        wait_idle(0);

        // stall three cycles while in RD
        issue(0, SIZE_WORD, 0, 32'h10, 0, 1, 32'h1122AA44, 0, 3, 0);
        wait_idle(0);

        // address wrap above the word index
        issue(0, SIZE_BYTE, 0, 32'hFFFF_FC11, 0, 1, 32'h000000AA, 0, 0, 0);
        wait_idle(0);

        // reset while in RD_WAIT aborts the load
        issue(0, SIZE_WORD, 0, 32'h10, 0, 1, 32'h1122AA44, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        issue(0, SIZE_WORD, 0, 32'h10, 0, 1, 32'h1122AA44, 0, 0, 0);
        wait_idle(0);

        // randomized traffic with stalls and memory delays
        extra_en = 1;
        for (int n = 0; n < 300; n++) begin
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SIZE_WORD) a[1:0] = 2'b00;
                else if (sz == SIZE_HALF) a[0] = 1'b0;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  a, $urandom, 0, 0, 0, 0, 1);
        end
        wait_idle(1);
        pipe_stall = 1'b0;
        repeat (4) @(posedge clk);

        if (q.size() != 0) begin
            $display("FAIL missing_resp: got %0d pending want 0", q.size());
            tmo_cnt += q.size();
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt + tmo_cnt);
        $finish;
    end

endmodule
